// File: rtl/gsim_pkg.sv
// Shared constants, types and the shift-and-add helper for the GSIM
// right-hand-side generator.
package gsim_pkg;

  localparam int N     = 16;
  localparam int CNT_W = $clog2(N);
  localparam int XW    = 32;
  localparam int ACC_W = 40;
  localparam int TAPS  = 7;

  // Magnitudes of the band coefficients: diagonal, |i-j| = 1, 2, 3.
  localparam int C_DIAG = 20;
  localparam int C_D1   = 13;
  localparam int C_D2   = 6;
  localparam int C_D3   = 1;

  typedef enum logic {RECV, CALC} state_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // The coefficient is constant at every call site, so this folds down to a
  // few shifted adds.
  function automatic acc_t shadd(input acc_t v, input int c);
    acc_t s;
    s = '0;
    for (int b = 0; b < 8; b++)
      if (c[b]) s = s + (v <<< b);
    return s;
  endfunction

endpackage

// File: rtl/gsim_band_row.sv
// One row of the band matrix product: seven taps centred on the diagonal.
// The caller zeroes any tap that falls outside the vector.
module gsim_band_row
  import gsim_pkg::*;
(
  input  logic [TAPS-1:0][XW-1:0] taps,
  output acc_t                    row_sum
);

  acc_t x [TAPS];

  always_comb begin
    for (int t = 0; t < TAPS; t++)
      x[t] = acc_t'($signed(taps[t]));
  end

  // taps[3] sits on the diagonal; symmetric pairs share one coefficient.
  always_comb
    row_sum = shadd(x[3], C_DIAG)
            - shadd(x[2] + x[4], C_D1)
            + shadd(x[1] + x[5], C_D2)
            - shadd(x[0] + x[6], C_D3);

endmodule

// File: rtl/gsim_bgen.sv
// Collects a 16-element Q16.16 vector, then streams b = A*x out one row per
// cycle through a two-stage pipeline (row sum, then round and saturate).
module gsim_bgen
  import gsim_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_en,
  input  logic signed [31:0]   x_in,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [15:0]   b_out
);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W:0]          step;
  logic signed [XW-1:0]    x_buf [N];
  logic [TAPS-1:0][XW-1:0] taps;
  acc_t                    row_sum;
  acc_t                    s1_sum;
  logic                    s1_valid;
  acc_t                    rounded;
  logic signed [15:0]      sat;

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    int idx;
    taps = '0;
    for (int t = 0; t < TAPS; t++) begin
      idx = int'(step[CNT_W-1:0]) + t - 3;
      if (idx >= 0 && idx < N) taps[t] = x_buf[idx[CNT_W-1:0]];
    end
  end

  gsim_band_row u_row (
    .taps    (taps),
    .row_sum (row_sum)
  );

  always_comb begin
    rounded = (s1_sum + (acc_t'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    sat     = rounded[15:0];
    if (rounded > 32767)       sat = 16'sh7FFF;
    else if (rounded < -32768) sat = -16'sh8000;
  end

  // NOTE: storage-only registers carry no reset; their contents are never
  // observed until the control logic has rewritten them.
  always_ff @(posedge clk) begin
    if (state == RECV && in_en) x_buf[cnt] <= x_in;
    if (state == CALC && step < (CNT_W+1)'(N)) s1_sum <= row_sum;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RECV;
      cnt       <= '0;
      step      <= '0;
      busy      <= 1'b0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      b_out     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) b_out <= sat;
      s1_valid <= 1'b0;
      case (state)
        RECV: begin
          if (in_en) begin
            if (cnt == CNT_W'(N - 1)) begin
              cnt   <= '0;
              step  <= '0;
              state <= CALC;
              busy  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CALC: begin
          // Rows issue on steps 0..15; two more steps drain the pipeline.
          if (step < (CNT_W+1)'(N)) s1_valid <= 1'b1;
          if (step == (CNT_W+1)'(N + 1)) begin
            step  <= '0;
            state <= RECV;
            busy  <= 1'b0;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_bgen.sv
// Scoreboard bench for gsim_bgen: directed frames with known results plus
// random frames checked against a plain matrix-product model.
module tb_gsim_bgen;

  typedef logic signed [31:0] vec_t [16];

  logic               clk = 1'b0;
  logic               reset;
  logic               in_en;
  logic signed [31:0] x_in;
  logic               busy;
  logic               out_valid;
  logic signed [15:0] b_out;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q [$];
  int last_exp = 0;

  gsim_bgen #(.FRAC_BITS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .busy      (busy),
    .out_valid (out_valid),
    .b_out     (b_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int coef(input int d);
    case (d < 0 ? -d : d)
      0:       return 20;
      1:       return -13;
      2:       return 6;
      3:       return -1;
      default: return 0;
    endcase
  endfunction

  // b = A*x in exact integer arithmetic, then round half up and clamp.
  function automatic int model_b(input vec_t xs, input int i);
    longint sum;
    longint r;
    sum = 0;
    for (int j = 0; j < 16; j++)
      sum += longint'(coef(i - j)) * longint'(xs[j]);
    r = (sum + 64'sd32768) >>> 16;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a row, and checks
  // that b_out holds its previous value otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got b_out=%0d with empty scoreboard at %0t",
                   b_out, $time);
        end else begin
          last_exp = exp_q.pop_front();
          check("b_out", int'(b_out), last_exp);
        end
      end else begin
        check("b_out_hold", int'(b_out), last_exp);
      end
    end
  end

  // Drives one frame, then walks the 18 cycles after E0 checking busy and
  // out_valid timing. With hold set, in_en stays high through CALC with junk.
  task automatic send_frame(input vec_t xs, input bit gaps, input bit hold);
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          in_en = 1'b0;
          x_in  = $urandom;
        end
      end
      @(negedge clk);
      in_en = 1'b1;
      x_in  = xs[k];
    end
    @(negedge clk);
    check("busy_at_e0", int'(busy), 1);
    check("valid_at_e0", int'(out_valid), 0);
    in_en = hold;
    x_in  = $urandom;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      check($sformatf("valid_e0+%0d", c), int'(out_valid), (c >= 2 && c <= 17) ? 1 : 0);
      check($sformatf("busy_e0+%0d", c), int'(busy), (c <= 17) ? 1 : 0);
      in_en = hold && (c <= 17);
      x_in  = $urandom;
    end
    in_en = 1'b0;
  endtask

  task automatic push_list(input int v [16]);
    for (int i = 0; i < 16; i++) exp_q.push_back(v[i]);
  endtask

  task automatic push_model(input vec_t xs);
    for (int i = 0; i < 16; i++) exp_q.push_back(model_b(xs, i));
  endtask

  initial begin
    vec_t xs;
    int   ones_b [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    int   imp_b  [16] = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
    int   half_b [16] = '{10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int   sat_b  [16];

    reset = 1'b1;
    in_en = 1'b0;
    x_in  = '0;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_b_out", int'(b_out), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // All ones, contiguous.
    foreach (xs[i]) xs[i] = 32'sh0001_0000;
    push_list(ones_b);
    send_frame(xs, 1'b0, 1'b0);

    // Impulse at x[5].
    foreach (xs[i]) xs[i] = (i == 5) ? 32'sh0001_0000 : 32'sh0;
    push_list(imp_b);
    send_frame(xs, 1'b0, 1'b0);

    // Half at x[0]: exercises half-up rounding of negative values.
    foreach (xs[i]) xs[i] = (i == 0) ? 32'sh0000_8000 : 32'sh0;
    push_list(half_b);
    send_frame(xs, 1'b0, 1'b0);

    // Alternating extremes saturate both ways.
    foreach (xs[i]) begin
      xs[i]    = (i % 2 == 0) ? 32'sh7FFF_0000 : 32'sh8001_0000;
      sat_b[i] = (i % 2 == 0) ? 32767 : -32768;
    end
    push_list(sat_b);
    send_frame(xs, 1'b0, 1'b0);

    // Gaps in input, junk held on in_en during CALC, then a clean frame to
    // show the ignored samples did not move cnt.
    foreach (xs[i]) xs[i] = 32'sh0001_0000;
    push_list(ones_b);
    send_frame(xs, 1'b1, 1'b1);
    foreach (xs[i]) xs[i] = (i == 5) ? 32'sh0001_0000 : 32'sh0;
    push_list(imp_b);
    send_frame(xs, 1'b1, 1'b0);

    // Reset at E0+5 aborts the frame.
    foreach (xs[i]) xs[i] = 32'sh0001_0000;
    push_list(ones_b);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_en = 1'b1;
      x_in  = xs[k];
    end
    @(negedge clk);
    in_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    exp_q.delete();
    last_exp = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Random frames against the reference model.
    for (int f = 0; f < 6; f++) begin
      foreach (xs[i]) begin
        if (f % 3 == 2) xs[i] = $urandom;
        else xs[i] = 32'($signed($urandom_range(0, 32'h0040_0000))) - 32'sh0020_0000;
      end
      push_model(xs);
      send_frame(xs, f[0], f[1]);
    end

    repeat (4) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
